// File: rtl/pc_sequencer.sv
// pc_sequencer: two-phase fetch/execute sequencer for the 16-bit core.
// Drives the fetch PC, latches the instruction word, resolves the next PC from
// jump/branch/return requests, and enters interrupts through a fixed vector.
module pc_sequencer #(
    parameter int unsigned         PC_W       = 16,
    parameter logic [PC_W-1:0]     RESET_PC   = PC_W'(1),
    parameter logic [PC_W-1:0]     IRQ_VECTOR = PC_W'(0)
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic [15:0]     INSTR,
    input  logic            STALL,
    input  logic            BR_TAKEN,
    input  logic [15:0]     BR_OFFSET,
    input  logic            JMP_EN,
    input  logic [15:0]     JMP_ADDR,
    input  logic            IRET,
    input  logic            IRQ,
    output logic [PC_W-1:0] PC,
    output logic [15:0]     IR,
    output logic            IR_VALID,
    output logic [PC_W-1:0] EPC,
    output logic            IE,
    output logic            IRQ_ACK,
    output logic [1:0]      STATE
);

    typedef enum logic [1:0] {
        StFetch = 2'd0,
        StExec  = 2'd1,
        StInt   = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     ir_q, ir_d;
    logic            valid_q, valid_d;
    logic [PC_W-1:0] epc_q, epc_d;
    logic            ie_q, ie_d;
    logic            ack_q, ack_d;

    logic [PC_W-1:0] br_off_ext;
    logic [PC_W-1:0] next_pc;
    logic            take_irq;

    // Resolve the next PC with jump > branch > return > sequential priority
    always_comb begin
        br_off_ext = PC_W'($signed(BR_OFFSET));
        if (JMP_EN) begin
            next_pc = PC_W'(JMP_ADDR);
        end else if (BR_TAKEN) begin
            next_pc = pc_q + PC_W'(1) + br_off_ext;
        end else if (IRET) begin
            next_pc = epc_q;
        end else begin
            next_pc = pc_q + PC_W'(1);
        end
        // A return in the same cycle defers a pending request to the next EXEC
        take_irq = IRQ && ie_q && !IRET;
    end

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a stall freezes the phase
    always_comb begin
        state_d = state_q;
        if (!STALL) begin
            unique case (state_q)
                StFetch: state_d = StExec;
                StExec:  state_d = take_irq ? StInt : StFetch;
                StInt:   state_d = StFetch;
                default: state_d = StFetch;
            endcase
        end
    end

    // Datapath next values; everything holds while stalled
    always_comb begin
        pc_d    = pc_q;
        ir_d    = ir_q;
        valid_d = valid_q;
        epc_d   = epc_q;
        ie_d    = ie_q;
        ack_d   = ack_q;
        if (!STALL) begin
            ack_d = 1'b0;
            unique case (state_q)
                StFetch: begin
                    ir_d    = INSTR;
                    valid_d = 1'b1;
                end
                StExec: begin
                    valid_d = 1'b0;
                    // IE is only re-enabled when the return actually wins priority
                    if (!JMP_EN && !BR_TAKEN && IRET) begin
                        ie_d = 1'b1;
                    end
                    if (take_irq) begin
                        epc_d = next_pc;
                        pc_d  = IRQ_VECTOR;
                        ie_d  = 1'b0;
                        ack_d = 1'b1;
                    end else begin
                        pc_d = next_pc;
                    end
                end
                StInt: begin
                    valid_d = 1'b0;
                end
                default: begin
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pc_q    <= RESET_PC;
            ir_q    <= 16'h0000;
            valid_q <= 1'b0;
            epc_q   <= '0;
            ie_q    <= 1'b1;
            ack_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            valid_q <= valid_d;
            epc_q   <= epc_d;
            ie_q    <= ie_d;
            ack_q   <= ack_d;
        end
    end

    // Outputs; the acknowledge is suppressed while the pipeline is held
    always_comb begin
        PC       = pc_q;
        IR       = ir_q;
        IR_VALID = valid_q;
        EPC      = epc_q;
        IE       = ie_q;
        IRQ_ACK  = ack_q && !STALL;
        STATE    = state_q;
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scenarios plus randomized requests, all checked
// every cycle against a behavioural model of the sequencer.
module tb_pc_sequencer;

    logic        CLK;
    logic        RST_N;
    logic [15:0] INSTR;
    logic        STALL;
    logic        BR_TAKEN;
    logic [15:0] BR_OFFSET;
    logic        JMP_EN;
    logic [15:0] JMP_ADDR;
    logic        IRET;
    logic        IRQ;
    logic [15:0] PC;
    logic [15:0] IR;
    logic        IR_VALID;
    logic [15:0] EPC;
    logic        IE;
    logic        IRQ_ACK;
    logic [1:0]  STATE;

    logic [15:0] mem [0:65535];

    int n_cmp = 0;
    int n_err = 0;

    // model state
    logic [15:0] m_pc, m_ir, m_epc;
    logic        m_valid, m_ie;
    int          m_st;

    pc_sequencer dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .INSTR     (INSTR),
        .STALL     (STALL),
        .BR_TAKEN  (BR_TAKEN),
        .BR_OFFSET (BR_OFFSET),
        .JMP_EN    (JMP_EN),
        .JMP_ADDR  (JMP_ADDR),
        .IRET      (IRET),
        .IRQ       (IRQ),
        .PC        (PC),
        .IR        (IR),
        .IR_VALID  (IR_VALID),
        .EPC       (EPC),
        .IE        (IE),
        .IRQ_ACK   (IRQ_ACK),
        .STATE     (STATE)
    );

    assign INSTR = mem[PC];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_pc    = 16'd1;
        m_ir    = 16'h0000;
        m_epc   = 16'h0000;
        m_valid = 1'b0;
        m_ie    = 1'b1;
        m_st    = 0;
    endtask

    // One instruction-phase step of the model, from the rules of operation
    task automatic m_step();
        logic [15:0] nxt;
        if (!RST_N) begin
            m_reset();
        end else if (!STALL) begin
            if (m_st == 0) begin
                m_ir    = mem[m_pc];
                m_valid = 1'b1;
                m_st    = 1;
            end else if (m_st == 1) begin
                if (JMP_EN)        nxt = JMP_ADDR;
                else if (BR_TAKEN) nxt = m_pc + 16'd1 + BR_OFFSET;
                else if (IRET)     nxt = m_epc;
                else               nxt = m_pc + 16'd1;
                m_valid = 1'b0;
                if (IRQ && m_ie && !IRET) begin
                    m_epc = nxt;
                    m_pc  = 16'd0;
                    m_ie  = 1'b0;
                    m_st  = 2;
                end else begin
                    if (!JMP_EN && !BR_TAKEN && IRET) m_ie = 1'b1;
                    m_pc = nxt;
                    m_st = 0;
                end
            end else begin
                m_st = 0;
            end
        end
    endtask

    task automatic cmp_model();
        chk("pc", 32'(PC), 32'(m_pc));
        chk("ir", 32'(IR), 32'(m_ir));
        chk("ir_valid", 32'(IR_VALID), 32'(m_valid));
        chk("epc", 32'(EPC), 32'(m_epc));
        chk("ie", 32'(IE), 32'(m_ie));
        chk("irq_ack", 32'(IRQ_ACK), 32'((m_st == 2) && !STALL));
        chk("state", 32'(STATE), 32'(m_st));
    endtask

    // Advance one clock: model updates with the DUT, compare on the falling edge
    task automatic tick();
        @(posedge CLK);
        m_step();
        @(negedge CLK);
        cmp_model();
    endtask

    task automatic idle_inputs();
        STALL     = 1'b0;
        BR_TAKEN  = 1'b0;
        BR_OFFSET = 16'h0000;
        JMP_EN    = 1'b0;
        JMP_ADDR  = 16'h0000;
        IRET      = 1'b0;
        IRQ       = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        mem[1] = 16'h3011;
        mem[2] = 16'hE011;
        mem[4] = 16'h3121;
        idle_inputs();
        RST_N = 1'b0;
        m_reset();
        tick();
        tick();
        chk("rst_pc", 32'(PC), 32'h1);
        chk("rst_ir", 32'(IR), 32'h0);
        chk("rst_ie", 32'(IE), 32'h1);
        chk("rst_state", 32'(STATE), 32'h0);

        // Sequential run
        RST_N = 1'b1;
        #1;
        chk("release_no_edge_state", 32'(STATE), 32'h0);
        tick();
        chk("fetch1_ir", 32'(IR), 32'h3011);
        chk("fetch1_state", 32'(STATE), 32'h1);
        chk("fetch1_valid", 32'(IR_VALID), 32'h1);
        tick();
        chk("seq_pc", 32'(PC), 32'h2);
        chk("seq_state", 32'(STATE), 32'h0);
        tick();
        chk("fetch2_ir", 32'(IR), 32'hE011);

        // Forward branch skips address 3
        BR_TAKEN = 1'b1; BR_OFFSET = 16'h0001;
        tick();
        chk("br_fwd_pc", 32'(PC), 32'h4);
        idle_inputs();
        tick();
        chk("fetch4_ir", 32'(IR), 32'h3121);

        // Interrupt entry at PC=4
        IRQ = 1'b1;
        tick();
        chk("irq_pc", 32'(PC), 32'h0);
        chk("irq_epc", 32'(EPC), 32'h5);
        chk("irq_ie", 32'(IE), 32'h0);
        chk("irq_ack", 32'(IRQ_ACK), 32'h1);
        chk("irq_state", 32'(STATE), 32'h2);
        tick();
        chk("irq_ack_drop", 32'(IRQ_ACK), 32'h0);
        tick();
        tick();
        chk("irq_masked_pc", 32'(PC), 32'h1);
        chk("irq_masked_state", 32'(STATE), 32'h0);
        tick();
        IRET = 1'b1;
        tick();
        chk("iret_pc", 32'(PC), 32'h5);
        chk("iret_ie", 32'(IE), 32'h1);
        chk("iret_defers_irq", 32'(STATE), 32'h0);
        idle_inputs();
        tick();

        // Backward branch
        BR_TAKEN = 1'b1; BR_OFFSET = 16'hFFFE;
        tick();
        chk("br_back_pc", 32'(PC), 32'h4);
        idle_inputs();
        tick();

        // Jump beats branch
        JMP_EN = 1'b1; JMP_ADDR = 16'h0001; BR_TAKEN = 1'b1; BR_OFFSET = 16'h0007;
        tick();
        chk("jmp_prio_pc", 32'(PC), 32'h1);
        idle_inputs();
        tick();
        JMP_EN = 1'b1; JMP_ADDR = 16'hFFFF;
        tick();
        chk("jmp_top_pc", 32'(PC), 32'hFFFF);
        idle_inputs();
        tick();
        tick();
        chk("wrap_pc", 32'(PC), 32'h0);
        tick();

        // Stall mid-EXEC with a pending branch
        STALL = 1'b1; BR_TAKEN = 1'b1; BR_OFFSET = 16'h0003;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", 32'(PC), 32'h0);
            chk("stall_state", 32'(STATE), 32'h1);
        end
        STALL = 1'b0;
        tick();
        chk("post_stall_pc", 32'(PC), 32'h4);
        idle_inputs();
        tick();

        // Asynchronous reset while in INT
        IRQ = 1'b1;
        tick();
        chk("int_again_state", 32'(STATE), 32'h2);
        idle_inputs();
        #2 RST_N = 1'b0;
        #1;
        chk("async_pc", 32'(PC), 32'h1);
        chk("async_epc", 32'(EPC), 32'h0);
        chk("async_ie", 32'(IE), 32'h1);
        chk("async_state", 32'(STATE), 32'h0);
        chk("async_ack", 32'(IRQ_ACK), 32'h0);
        m_reset();
        tick();
        RST_N = 1'b1;

        // Randomized requests
        for (int c = 0; c < 4000; c++) begin
            STALL     = ($urandom_range(0, 7) == 0);
            JMP_EN    = ($urandom_range(0, 15) == 0);
            JMP_ADDR  = 16'($urandom);
            BR_TAKEN  = ($urandom_range(0, 3) == 0);
            BR_OFFSET = 16'($urandom);
            IRET      = ($urandom_range(0, 11) == 0);
            IRQ       = ($urandom_range(0, 5) == 0);
            RST_N     = ($urandom_range(0, 599) != 0);
            tick();
        end
        RST_N = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
